// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-requester I2C arbiter: FSM states,
// requester count and counter widths.
package i2c_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;
  localparam int WD_W    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    BUSY   = 3'd2,
    BYTE   = 3'd3,
    FINISH = 3'd4
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational two-way round-robin pick: the requester not served last
// gets priority; output is one-hot or zero.
module i2c_rr_pick import i2c_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // Requester 1 leads only when requester 0 was the last one served.
  always_comb begin
    grant = 2'b00;
    if (last_grant == 2'b01) begin
      if (req[1]) begin
        grant = 2'b10;
      end else if (req[0]) begin
        grant = 2'b01;
      end else begin
        grant = 2'b00;
      end
    end else begin
      if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end else begin
        grant = 2'b00;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Two-requester front end for one I2C byte master: round-robin grant, per-byte
// handshake and abort. Define I2C_ARB_TIMEOUT_EN to add the per-byte watchdog.
module i2c_req_arbiter import i2c_arb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  req_rw,
  input  logic [6:0]          req_addr0,
  input  logic [6:0]          req_addr1,
  input  logic [CNT_W-1:0]    req_len0,
  input  logic [CNT_W-1:0]    req_len1,
  input  logic [7:0]          req_wdata0,
  input  logic [7:0]          req_wdata1,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  byte_ack,
  output logic [7:0]          rdata,
  output logic [NUM_REQ-1:0]  done,
  output logic [NUM_REQ-1:0]  err,
  output logic                m_start,
  output logic                m_rw,
  output logic [6:0]          m_addr,
  output logic [7:0]          m_data_in,
  output logic                m_more_data,
  input  logic [7:0]          m_data_out,
  input  logic                m_ready,
  input  logic                m_error
);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  last_q, last_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  byte_ack_q, byte_ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                m_start_q, m_start_d;
  logic                m_rw_q, m_rw_d;
  logic [6:0]          m_addr_q, m_addr_d;
  logic                m_more_q, m_more_d;

  logic [NUM_REQ-1:0]  req_avail_s;
  logic [NUM_REQ-1:0]  pick_s;
  logic                sel_rw_s;
  logic [6:0]          sel_addr_s;
  logic [CNT_W-1:0]    sel_len_s;
  logic                in_xfer_s;
  logic                wd_expire_s;
  logic                abort_s;

  // A requester whose done pulse is showing is treated as already released.
  assign req_avail_s = req & ~done_q;

  i2c_rr_pick u_pick (
    .req        (req_avail_s),
    .last_grant (last_q),
    .grant      (pick_s)
  );

  assign sel_rw_s   = pick_s[1] ? req_rw[1]  : req_rw[0];
  assign sel_addr_s = pick_s[1] ? req_addr1  : req_addr0;
  assign sel_len_s  = pick_s[1] ? req_len1   : req_len0;
  assign in_xfer_s  = (state_q == BUSY) || (state_q == BYTE);
  assign abort_s    = in_xfer_s && (m_error || wd_expire_s);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;

  assign wd_expire_s = in_xfer_s && (wd_q == WD_LAST);

  // Watchdog restarts on each completed byte and outside BUSY/BYTE.
  always_comb begin
    if (in_xfer_s && !abort_s && (byte_ack_d == 2'b00)) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = {WD_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= {WD_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expire_s = 1'b0;
`endif

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    byte_ack_d = 2'b00;
    done_d     = 2'b00;
    err_d      = 2'b00;
    rdata_d    = rdata_q;
    m_start_d  = 1'b0;
    m_rw_d     = m_rw_q;
    m_addr_d   = m_addr_q;
    m_more_d   = m_more_q;
    case (state_q)
      IDLE: begin
        if (m_ready && (pick_s != 2'b00)) begin
          grant_d   = pick_s;
          last_d    = pick_s;
          len_d     = sel_len_s;
          cnt_d     = 4'd0;
          m_start_d = 1'b1;
          m_rw_d    = sel_rw_s;
          m_addr_d  = sel_addr_s;
          m_more_d  = (sel_len_s != 4'd0);
          state_d   = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        state_d = BUSY;
      end
      BUSY, BYTE: begin
        if (abort_s) begin
          done_d   = grant_q;
          err_d    = grant_q;
          grant_d  = 2'b00;
          m_rw_d   = 1'b0;
          m_addr_d = 7'h00;
          m_more_d = 1'b0;
          state_d  = IDLE;
        end else if (state_q == BUSY) begin
          if (!m_ready) begin
            state_d = BYTE;
          end else begin
            state_d = BUSY;
          end
        end else if (m_ready) begin
          // BYTE is only held while m_ready is low, so a high here is the rising edge.
          byte_ack_d = grant_q;
          if (m_rw_q) begin
            rdata_d = m_data_out;
          end else begin
            rdata_d = rdata_q;
          end
          if (cnt_q < len_q) begin
            cnt_d    = cnt_q + 4'd1;
            m_more_d = ((cnt_q + 4'd1) < len_q);
            state_d  = BUSY;
          end else begin
            state_d = FINISH;
          end
        end else begin
          state_d = BYTE;
        end
      end
      FINISH: begin
        done_d   = grant_q;
        grant_d  = 2'b00;
        m_rw_d   = 1'b0;
        m_addr_d = 7'h00;
        m_more_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        grant_d  = 2'b00;
        m_rw_d   = 1'b0;
        m_addr_d = 7'h00;
        m_more_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers; requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      last_q     <= 2'b10;
      len_q      <= 4'd0;
      cnt_q      <= 4'd0;
      byte_ack_q <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata_q    <= 8'h00;
      m_start_q  <= 1'b0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= 7'h00;
      m_more_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      byte_ack_q <= byte_ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      m_start_q  <= m_start_d;
      m_rw_q     <= m_rw_d;
      m_addr_q   <= m_addr_d;
      m_more_q   <= m_more_d;
    end
  end

  // Write data follows the current owner's byte without a register stage.
  always_comb begin
    if (grant_q[1]) begin
      m_data_in = req_wdata1;
    end else if (grant_q[0]) begin
      m_data_in = req_wdata0;
    end else begin
      m_data_in = 8'h00;
    end
  end

  assign grant       = grant_q;
  assign byte_ack    = byte_ack_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_start     = m_start_q;
  assign m_rw        = m_rw_q;
  assign m_addr      = m_addr_q;
  assign m_more_data = m_more_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed, table-driven bench for i2c_req_arbiter plus hand-written timeout
// and asynchronous-reset sequences.
module tb_i2c_req_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_rw;
  logic [6:0] req_addr0;
  logic [6:0] req_addr1;
  logic [3:0] req_len0;
  logic [3:0] req_len1;
  logic [7:0] req_wdata0;
  logic [7:0] req_wdata1;
  logic [1:0] grant;
  logic [1:0] byte_ack;
  logic [7:0] rdata;
  logic [1:0] done;
  logic [1:0] err;
  logic       m_start;
  logic       m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic       m_more_data;
  logic [7:0] m_data_out;
  logic       m_ready;
  logic       m_error;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  rw;
    logic [3:0]  len0;
    logic [3:0]  len1;
    logic [7:0]  wd0;
    logic [7:0]  wd1;
    logic [7:0]  dout;
    logic        rdy;
    logic        merr;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[$];

  i2c_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_rw     (req_rw),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_len0   (req_len0),
    .req_len1   (req_len1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .grant      (grant),
    .byte_ack   (byte_ack),
    .rdata      (rdata),
    .done       (done),
    .err        (err),
    .m_start    (m_start),
    .m_rw       (m_rw),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_more_data(m_more_data),
    .m_data_out (m_data_out),
    .m_ready    (m_ready),
    .m_error    (m_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle: grant, byte_ack, done, err, m_start, m_more_data, m_rw, m_addr, m_data_in, rdata
  function automatic logic [33:0] e(input logic [1:0] g, input logic [1:0] a, input logic [1:0] d,
                                    input logic [1:0] er, input logic s, input logic m, input logic rw,
                                    input logic [6:0] ad, input logic [7:0] din, input logic [7:0] rd);
    return {g, a, d, er, s, m, rw, ad, din, rd};
  endfunction

  function automatic logic [33:0] actual();
    return {grant, byte_ack, done, err, m_start, m_more_data, m_rw, m_addr, m_data_in, rdata};
  endfunction

  task automatic add(input logic [1:0] rq, input logic [1:0] rw, input logic [3:0] l0, input logic [3:0] l1,
                     input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] dout, input logic rdy,
                     input logic merr, input logic [33:0] ex);
    vec_t v;
    v.req = rq; v.rw = rw; v.len0 = l0; v.len1 = l1; v.wd0 = w0; v.wd1 = w1;
    v.dout = dout; v.rdy = rdy; v.merr = merr; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  int  n;
  bit  seen;
  logic [5:0] snap;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; req = 2'b00; req_rw = 2'b00; req_addr0 = 7'h50; req_addr1 = 7'h21;
    req_len0 = 4'd0; req_len1 = 4'd0; req_wdata0 = 8'h00; req_wdata1 = 8'h00;
    m_data_out = 8'h00; m_ready = 1'b1; m_error = 1'b0;

    // Contention after reset: req0 write len 0, req1 read len 0 returning 0x3C
    add(2'b11, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h00, 1'b1, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 7'h50, 8'h11, 8'h00));
    add(2'b11, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h00, 1'b1, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h50, 8'h11, 8'h00));
    add(2'b11, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h00, 1'b0, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h50, 8'h11, 8'h00));
    add(2'b11, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h50, 8'h11, 8'h00));
    add(2'b11, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00));
    add(2'b10, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 7'h21, 8'h77, 8'h00));
    add(2'b10, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 7'h21, 8'h77, 8'h00));
    add(2'b10, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b0, 1'b0, e(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 7'h21, 8'h77, 8'h00));
    add(2'b10, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 7'h21, 8'h77, 8'h3C));
    add(2'b10, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h3C));
    add(2'b00, 2'b10, 4'd0, 4'd0, 8'h11, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h3C));
    // Single write: req0, addr 0x50, len 2, bytes A1/A2/A3
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 7'h50, 8'hA1, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h50, 8'hA1, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h77, 8'h3C, 1'b0, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h50, 8'hA1, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h77, 8'h3C, 1'b0, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h50, 8'hA1, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA1, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h50, 8'hA1, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA2, 8'h77, 8'h3C, 1'b0, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h50, 8'hA2, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA2, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h50, 8'hA2, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA3, 8'h77, 8'h3C, 1'b0, 1'b0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h50, 8'hA3, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA3, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h50, 8'hA3, 8'h3C));
    add(2'b01, 2'b00, 4'd2, 4'd0, 8'hA3, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h3C));
    add(2'b00, 2'b00, 4'd2, 4'd0, 8'hA3, 8'h77, 8'h3C, 1'b1, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h3C));
    // NACK on byte 0 of a requester-1 transfer: abort, no byte_ack
    add(2'b10, 2'b00, 4'd0, 4'd1, 8'hA3, 8'h5A, 8'h3C, 1'b1, 1'b0, e(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 7'h21, 8'h5A, 8'h3C));
    add(2'b10, 2'b00, 4'd0, 4'd1, 8'hA3, 8'h5A, 8'h3C, 1'b1, 1'b0, e(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h21, 8'h5A, 8'h3C));
    add(2'b10, 2'b00, 4'd0, 4'd1, 8'hA3, 8'h5A, 8'h3C, 1'b0, 1'b0, e(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 7'h21, 8'h5A, 8'h3C));
    add(2'b10, 2'b00, 4'd0, 4'd1, 8'hA3, 8'h5A, 8'h3C, 1'b1, 1'b1, e(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h3C));
    add(2'b00, 2'b00, 4'd0, 4'd1, 8'hA3, 8'h5A, 8'h3C, 1'b1, 1'b0, e(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h3C));

    step();
    step();
    chk("reset_outputs", actual(), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; req_rw = vecs[i].rw; req_len0 = vecs[i].len0; req_len1 = vecs[i].len1;
      req_wdata0 = vecs[i].wd0; req_wdata1 = vecs[i].wd1; m_data_out = vecs[i].dout;
      m_ready = vecs[i].rdy; m_error = vecs[i].merr;
      step();
      chk($sformatf("row%0d", i), actual(), vecs[i].exp);
    end

    // Watchdog: req0 granted, m_ready then held low
    req = 2'b01; req_rw = 2'b00; req_len0 = 4'd0; m_ready = 1'b1; m_error = 1'b0;
    step();
    m_ready = 1'b0;
    step();
    chk("wd_busy_entry", {grant, m_start}, {2'b01, 1'b0});
    n = 0; seen = 1'b0; snap = 6'd0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (err != 2'b00) begin
        seen = 1'b1;
        snap = {done, err, grant};
      end
    end
`ifdef I2C_ARB_TIMEOUT_EN
    chk("wd_cycles", n, 16);
    chk("wd_abort", snap, {2'b01, 2'b01, 2'b00});
`else
    chk("wd_absent", seen, 1'b0);
    chk("wd_still_owned", {grant, done}, {2'b01, 2'b00});
`endif
    req = 2'b00;
    m_ready = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;

    // Asynchronous reset during byte 1 of a 2-byte read
    req = 2'b01; req_rw = 2'b01; req_len0 = 4'd1; req_wdata0 = 8'hC4; m_ready = 1'b1;
    step();
    step();
    m_ready = 1'b0;
    step();
    m_ready = 1'b1; m_data_out = 8'h99;
    step();
    chk("read_byte0", {byte_ack, rdata}, {2'b01, 8'h99});
    m_ready = 1'b0;
    step();
    chk("byte1_owned", {grant, m_more_data}, {2'b01, 1'b0});
    #2 rst = 1'b0;
    #1 chk("async_reset", actual(), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("reset_quiet%0d", k), {done, err, grant}, 6'd0);
    end
    rst = 1'b1; m_ready = 1'b1;
    step();
    chk("regrant_after_reset", actual(), {30'd0, e(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 7'h50, 8'hC4, 8'h00)});
    req = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
